// File: rtl/out_port_arbiter_pkg.sv
// Shared NoC definitions: flit type field position, type codes and the
// output-port arbiter FSM encoding.
package out_port_arbiter_pkg;

    localparam int          FLIT_TYPE_LSB = 0;
    localparam int          FLIT_TYPE_W   = 2;
    localparam logic [15:0] FLIT_CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic flit_type_e decode_flit_type(input logic [FLIT_TYPE_W-1:0] bits);
        return flit_type_e'(bits);
    endfunction

    // TAIL and SINGLE both close a packet and release the output port.
    function automatic logic ends_packet(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/out_port_arbiter_rr_pick.sv
// Combinational N-way round-robin pick: first requester at or after ptr,
// wrapping modulo N.
module rr_pick
    import out_port_arbiter_pkg::*;
#(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any         = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// NoC output-port arbiter: round-robin between requesters, holding the port
// for the owner of a HEAD..TAIL packet, with a one-cycle registered output.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int DATASIZE = 40,
    parameter int NPORT    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NPORT-1:0]          req,
    input  logic [NPORT*DATASIZE-1:0] data_in,
    input  logic                      full_in,
    output logic [NPORT-1:0]          grant,
    output logic [DATASIZE-1:0]       data_out,
    output logic                      valid_out,
    output logic                      locked,
    output logic [15:0]               flit_cnt
);

    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [DATASIZE-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [NPORT-1:0]    pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;

    logic [NPORT-1:0]    owner_onehot;
    logic                owner_req;
    logic [IW-1:0]       sel_idx;
    logic [DATASIZE-1:0] sel_flit;
    flit_type_e          sel_type;
    logic                fire;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NPORT - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(
        .N  (NPORT),
        .IW (IW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign sel_idx = (state_q == ARB_LOCKED) ? owner_q : pick_idx;

    always_comb begin
        owner_onehot = '0;
        owner_req    = 1'b0;
        sel_flit     = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (owner_q == IW'(i)) begin
                owner_onehot[i] = 1'b1;
                owner_req       = req[i];
            end
            if (sel_idx == IW'(i)) begin
                sel_flit = data_in[i*DATASIZE +: DATASIZE];
            end
        end
    end

    assign sel_type = decode_flit_type(sel_flit[FLIT_TYPE_LSB +: FLIT_TYPE_W]);

    // The grant is gated by rst_n so nothing is consumed while reset is held.
    always_comb begin
        fire  = 1'b0;
        grant = '0;
        if (rst_n && !full_in) begin
            if (state_q == ARB_LOCKED) begin
                fire  = owner_req;
                grant = owner_req ? owner_onehot : '0;
            end else begin
                fire  = pick_any;
                grant = pick_onehot;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        data_d   = data_q;
        valid_d  = fire;
        cnt_d    = cnt_q;
        if (fire) begin
            data_d = sel_flit;
            if (cnt_q != FLIT_CNT_MAX) begin
                cnt_d = cnt_q + 16'd1;
            end
            if (state_q == ARB_IDLE) begin
                if (sel_type == FLIT_HEAD) begin
                    state_d = ARB_LOCKED;
                    owner_d = sel_idx;
                end else begin
                    rr_ptr_d = next_idx(sel_idx);
                end
            end else if (ends_packet(sel_type)) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = next_idx(owner_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign locked    = (state_q == ARB_LOCKED);
    assign flit_cnt  = cnt_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Self-checking bench for out_port_arbiter: directed vector table, reset and
// saturation sequences, and random traffic against a packet-level model.
module tb_out_port_arbiter;

    localparam int DW = 40;
    localparam int NP = 5;
    localparam logic [1:0] HD = 2'b00;
    localparam logic [1:0] BD = 2'b01;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [1:0] SG = 2'b11;

    logic              clk     = 1'b0;
    logic              rstN    = 1'b1;
    logic [NP-1:0]     req     = '0;
    logic [NP*DW-1:0]  dataIn  = '0;
    logic              fullIn  = 1'b0;
    logic [NP-1:0]     grant;
    logic [DW-1:0]     dataOut;
    logic              validOut;
    logic              locked;
    logic [15:0]       flitCnt;

    out_port_arbiter #(
        .DATASIZE (DW),
        .NPORT    (NP)
    ) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .req       (req),
        .data_in   (dataIn),
        .full_in   (fullIn),
        .grant     (grant),
        .data_out  (dataOut),
        .valid_out (validOut),
        .locked    (locked),
        .flit_cnt  (flitCnt)
    );

    always #5 clk = ~clk;

    int            nCompared   = 0;
    int            nMismatched = 0;
    int            tick        = 0;
    int            validPulses = 0;

    // Packet-level reference: who owns the port, where the search starts.
    bit            mLocked;
    int            mOwner;
    int            mPtr;
    int            mCnt;
    bit            mValid;
    logic [DW-1:0] mData;
    logic [DW-1:0] curFlit [NP];

    typedef struct {
        logic [NP-1:0]      req;
        logic [NP-1:0][1:0] tp;
        logic               full;
        logic [NP-1:0]      expGrant;
        logic               expLocked;
    } vec_t;

    vec_t vecs [19];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mLocked = 1'b0;
        mOwner  = 0;
        mPtr    = 0;
        mCnt    = 0;
        mValid  = 1'b0;
        mData   = '0;
    endtask

    function automatic int modelPick();
        if (fullIn || !rstN) return -1;
        if (mLocked) return req[mOwner] ? mOwner : -1;
        for (int k = 0; k < NP; k++) begin
            if (req[(mPtr + k) % NP]) return (mPtr + k) % NP;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [NP-1:0] r, input logic [NP-1:0][1:0] tp, input logic f);
        @(negedge clk);
        tick++;
        for (int i = 0; i < NP; i++) begin
            curFlit[i] = {4'(i), 4'(0), 8'(tick), 22'($urandom), tp[i]};
            dataIn[i*DW +: DW] = curFlit[i];
        end
        req    = r;
        fullIn = f;
        #1;
    endtask

    task automatic checkGrant(input string name);
        int            p;
        logic [NP-1:0] e;
        p = modelPick();
        e = '0;
        if (p >= 0) e[p] = 1'b1;
        checkOutput(name, 64'(grant), 64'(e));
    endtask

    task automatic stepClock(input bit doCheck);
        int         p;
        logic [1:0] t;
        p = modelPick();
        @(posedge clk);
        if (p >= 0) begin
            mValid = 1'b1;
            mData  = curFlit[p];
            if (mCnt < 65535) mCnt++;
            t = curFlit[p][1:0];
            if (!mLocked) begin
                if (t == HD) begin
                    mLocked = 1'b1;
                    mOwner  = p;
                end else begin
                    mPtr = (p + 1) % NP;
                end
            end else if (t == TL || t == SG) begin
                mLocked = 1'b0;
                mPtr    = (mOwner + 1) % NP;
            end
        end else begin
            mValid = 1'b0;
        end
        #1;
        if (validOut) validPulses++;
        if (doCheck) begin
            checkOutput("valid_out", 64'(validOut), 64'(mValid));
            checkOutput("data_out", 64'(dataOut), 64'(mData));
            checkOutput("locked", 64'(locked), 64'(mLocked));
            checkOutput("flit_cnt", 64'(flitCnt), 64'(mCnt));
        end
    endtask

    initial begin
        logic [NP-1:0][1:0] tp;

        vecs[0]  = '{5'b11111, {SG,SG,SG,SG,SG}, 1'b0, 5'b00001, 1'b0};
        vecs[1]  = '{5'b11111, {SG,SG,SG,SG,SG}, 1'b0, 5'b00010, 1'b0};
        vecs[2]  = '{5'b11111, {SG,SG,SG,SG,SG}, 1'b0, 5'b00100, 1'b0};
        vecs[3]  = '{5'b11111, {SG,SG,SG,SG,SG}, 1'b0, 5'b01000, 1'b0};
        vecs[4]  = '{5'b11111, {SG,SG,SG,SG,SG}, 1'b0, 5'b10000, 1'b0};
        vecs[5]  = '{5'b00010, {TL,TL,TL,TL,TL}, 1'b0, 5'b00010, 1'b0};
        vecs[6]  = '{5'b10101, {SG,SG,HD,SG,SG}, 1'b0, 5'b00100, 1'b1};
        vecs[7]  = '{5'b10101, {SG,SG,BD,SG,SG}, 1'b0, 5'b00100, 1'b1};
        vecs[8]  = '{5'b10101, {SG,SG,TL,SG,SG}, 1'b0, 5'b00100, 1'b0};
        vecs[9]  = '{5'b10001, {SG,SG,SG,SG,SG}, 1'b0, 5'b10000, 1'b0};
        vecs[10] = '{5'b01000, {SG,HD,SG,SG,SG}, 1'b0, 5'b01000, 1'b1};
        vecs[11] = '{5'b11001, {SG,BD,SG,SG,SG}, 1'b1, 5'b00000, 1'b1};
        vecs[12] = '{5'b11001, {SG,BD,SG,SG,SG}, 1'b1, 5'b00000, 1'b1};
        vecs[13] = '{5'b11001, {SG,BD,SG,SG,SG}, 1'b1, 5'b00000, 1'b1};
        vecs[14] = '{5'b11001, {SG,BD,SG,SG,SG}, 1'b1, 5'b00000, 1'b1};
        vecs[15] = '{5'b00011, {SG,BD,SG,SG,SG}, 1'b0, 5'b00000, 1'b1};
        vecs[16] = '{5'b11001, {SG,BD,SG,SG,SG}, 1'b0, 5'b01000, 1'b1};
        vecs[17] = '{5'b11001, {SG,TL,SG,SG,SG}, 1'b0, 5'b01000, 1'b0};
        vecs[18] = '{5'b00011, {SG,SG,SG,SG,SG}, 1'b0, 5'b00001, 1'b0};

        modelReset();
        #1 rstN = 1'b0;
        applyStimulus(5'b11111, {SG,SG,SG,SG,SG}, 1'b0);
        checkOutput("reset_grant", 64'(grant), 64'(0));
        checkOutput("reset_valid", 64'(validOut), 64'(0));
        checkOutput("reset_data", 64'(dataOut), 64'(0));
        checkOutput("reset_locked", 64'(locked), 64'(0));
        checkOutput("reset_cnt", 64'(flitCnt), 64'(0));
        req  = '0;
        rstN = 1'b1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].req, vecs[i].tp, vecs[i].full);
            checkOutput($sformatf("tbl%0d_grant", i), 64'(grant), 64'(vecs[i].expGrant));
            checkGrant($sformatf("tbl%0d_model_grant", i));
            stepClock(1'b1);
            checkOutput($sformatf("tbl%0d_locked", i), 64'(locked), 64'(vecs[i].expLocked));
            if (i == 4) begin
                checkOutput("rr_five_cnt", 64'(flitCnt), 64'(5));
                checkOutput("rr_five_pulses", 64'(validPulses), 64'(5));
            end
        end

        // Asynchronous reset in the middle of a packet from E.
        applyStimulus(5'b01000, {SG,HD,SG,SG,SG}, 1'b0);
        checkOutput("rst_head_grant", 64'(grant), 64'(5'b01000));
        stepClock(1'b1);
        checkOutput("rst_head_locked", 64'(locked), 64'(1));
        #2;
        req  = '0;
        rstN = 1'b0;
        #1;
        checkOutput("async_locked", 64'(locked), 64'(0));
        checkOutput("async_valid", 64'(validOut), 64'(0));
        checkOutput("async_cnt", 64'(flitCnt), 64'(0));
        checkOutput("async_data", 64'(dataOut), 64'(0));
        checkOutput("async_grant", 64'(grant), 64'(0));
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(5'b01010, {SG,BD,SG,SG,SG}, 1'b0);
        checkOutput("post_reset_w_first", 64'(grant), 64'(5'b00010));
        stepClock(1'b1);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NP; i++) tp[i] = 2'($urandom_range(0, 3));
            applyStimulus(NP'($urandom), tp, ($urandom_range(0, 3) == 0));
            checkGrant("rand_grant");
            stepClock(1'b1);
        end

        // Saturation: 65535 grants from a clean start, then one more.
        req = '0;
        @(negedge clk);
        rstN = 1'b0;
        #1 modelReset();
        @(negedge clk);
        rstN = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            applyStimulus(5'b00001, {SG,SG,SG,SG,SG}, 1'b0);
            stepClock(1'b0);
        end
        checkOutput("sat_preload", 64'(flitCnt), 64'(16'hFFFF));
        applyStimulus(5'b00001, {SG,SG,SG,SG,SG}, 1'b0);
        checkOutput("sat_grant", 64'(grant), 64'(5'b00001));
        stepClock(1'b1);
        checkOutput("sat_hold", 64'(flitCnt), 64'(16'hFFFF));
        checkOutput("sat_valid", 64'(validOut), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/out_port_arbiter.md
OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 SHALL have parameter DATASIZE, default 40, flit width (src 4, dst 4, timestamp 8, data 22, type 2 in bits [1:0]).
REQ-002 SHALL have parameter NPORT, default 5, requester count; index 0=L, 1=W, 2=N, 3=E, 4=S.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, NPORT bits: requester i has a flit routed to this output port.
REQ-006 SHALL have port data_in, input, NPORT*DATASIZE bits: requester i flit at slice [i*DATASIZE +: DATASIZE].
REQ-007 SHALL have port full_in, input, 1 bit: downstream input FIFO full.
REQ-008 SHALL have port grant, output, NPORT bits: one-hot, combinational; requester i's flit is consumed this cycle.
REQ-009 SHALL have port data_out, output, DATASIZE bits: registered forwarded flit.
REQ-010 SHALL have port valid_out, output, 1 bit: registered, high one cycle per forwarded flit.
REQ-011 SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-012 SHALL have port flit_cnt, output, 16 bits: saturating count of forwarded flits.

Function
REQ-013 Flit type SHALL be decoded from bits [1:0]: 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE.
REQ-014 FSM states SHALL be IDLE and LOCKED, plus registers rr_ptr (0..NPORT-1) and owner (0..NPORT-1).
REQ-015 grant SHALL be all-zero whenever full_in=1 or rst_n=0.
REQ-016 In IDLE with full_in=0, grant SHALL select the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NPORT.
REQ-017 In IDLE, a granted HEAD SHALL move the FSM to LOCKED with owner=i; rr_ptr is unchanged.
REQ-018 In IDLE, a granted SINGLE, BODY or TAIL SHALL leave the FSM in IDLE and set rr_ptr=(i+1) mod NPORT; stray BODY/TAIL are forwarded as if SINGLE.
REQ-019 In LOCKED, grant SHALL be asserted only to owner, only when req[owner]=1 and full_in=0; other requesters SHALL be ignored.
REQ-020 In LOCKED, a granted TAIL or SINGLE SHALL return the FSM to IDLE with rr_ptr=(owner+1) mod NPORT; a granted HEAD or BODY SHALL stay in LOCKED.
REQ-021 Latency SHALL be 1 cycle: after a grant at edge N, valid_out=1 and data_out=granted flit from edge N until edge N+1.
REQ-022 valid_out SHALL be 0 in any cycle following a cycle with no grant; data_out SHALL hold its last value.
REQ-023 flit_cnt SHALL increment on each grant and saturate at 16'hFFFF.
REQ-024 Back-to-back grants SHALL be possible every cycle, giving full throughput when full_in=0.
REQ-025 A full_in rise in LOCKED SHALL stall without releasing the lock; the FSM state is preserved indefinitely.

Reset
REQ-026 On rst_n=0, the block SHALL immediately force state=IDLE, rr_ptr=0, owner=0, valid_out=0, data_out=0 and flit_cnt=0.
REQ-027 Reset mid-packet SHALL drop the lock; no partial flit SHALL be emitted after reset release.

Structure
REQ-028 Flit-type codes, type field position, and FSM state encodings SHALL live in the shared NoC package.
REQ-029 One sub-module, rr_pick, SHALL implement a combinational NPORT-way round-robin priority pick (req, ptr -> one-hot, index, any).

Verification
REQ-030 Verify: req=5'b11111 with all SINGLE and full_in=0 for 5 cycles -> grants 0,1,2,3,4 in order, 5 valid_out pulses, flit_cnt=5.
REQ-031 Verify: N sends HEAD, BODY, TAIL with L and S requesting throughout -> grant=5'b00100 for 3 cycles, locked=1 for 2 cycles, then S (index 4) is granted next with rr_ptr=3 searching from E.
REQ-032 Verify: full_in=1 for 4 cycles during LOCKED -> grant=0 and valid_out=0 for those cycles, locked stays 1, and the packet resumes in order.
REQ-033 Verify: rst_n pulsed low after a HEAD from E -> locked=0, valid_out=0 and flit_cnt=0 asynchronously; after release, W with SINGLE is granted first.
REQ-034 Verify: a stray TAIL from W in IDLE -> forwarded, FSM stays IDLE, rr_ptr=2.
REQ-035 Verify: flit_cnt preloaded via 65535 grants, then 1 more grant -> flit_cnt stays 16'hFFFF.
